// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for the 5-stage pipeline.
// Detects D-stage operand hazards against E/M destinations using Tuse/Tnew timing.
// Tracks the multi-cycle multiply/divide unit with a busy countdown.
// Drives stall/flush for the F/D and D/E pipeline registers.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             useRsD,
    input  logic             useRtD,
    input  logic [1:0]       tuseRsD,
    input  logic [1:0]       tuseRtD,
    input  logic [4:0]       WriteRegE,
    input  logic [1:0]       tnewE,
    input  logic [4:0]       WriteRegM,
    input  logic [1:0]       tnewM,
    input  logic             mdStartE,
    input  logic             mdIsDivE,
    input  logic             mdUseD,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             mdBusy,
    output logic [CNT_W-1:0] mdCount,
    output logic [31:0]      stallCount
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic rs_e;
    logic rs_m;
    logic rt_e;
    logic rt_m;
    logic md_stall;
    logic stall;

    // A source operand stalls when its producer is still further from ready than the consumer can wait.
    always_comb begin
        rs_e     = useRsD && (rsD != 5'd0) && (rsD == WriteRegE) && (tnewE > tuseRsD);
        rs_m     = useRsD && (rsD != 5'd0) && (rsD == WriteRegM) && (tnewM > tuseRsD);
        rt_e     = useRtD && (rtD != 5'd0) && (rtD == WriteRegE) && (tnewE > tuseRtD);
        rt_m     = useRtD && (rtD != 5'd0) && (rtD == WriteRegM) && (tnewM > tuseRtD);
        md_stall = mdUseD && (mdBusy || mdStartE);
        stall    = rs_e || rs_m || rt_e || rt_m || md_stall;
    end

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;
    assign mdBusy = (mdCount != '0);

    // MDU busy countdown; a start while already counting is ignored since D holds MDU ops while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdCount <= '0;
        end else if (mdStartE && (mdCount == '0)) begin
            mdCount <= mdIsDivE ? DIV_LOAD : MULT_LOAD;
        end else if (mdCount != '0) begin
            mdCount <= mdCount - 1'b1;
        end
    end

    // Saturating count of cycles the pipeline front end was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsD, rtD, WriteRegE, WriteRegM;
    logic        useRsD, useRtD, mdStartE, mdIsDivE, mdUseD;
    logic [1:0]  tuseRsD, tuseRtD, tnewE, tnewM;
    logic        stallF, stallD, flushE, mdBusy;
    logic [3:0]  mdCount;
    logic [31:0] stallCount;

    int    total = 0;
    int    bad   = 0;
    int    m_count;
    longint m_stalls;

    pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .tuseRsD(tuseRsD), .tuseRtD(tuseRtD),
        .WriteRegE(WriteRegE), .tnewE(tnewE), .WriteRegM(WriteRegM), .tnewM(tnewM),
        .mdStartE(mdStartE), .mdIsDivE(mdIsDivE), .mdUseD(mdUseD),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mdBusy(mdBusy), .mdCount(mdCount), .stallCount(stallCount)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // One operand is hazardous if a pending writer of it will not be ready in time.
    function automatic bit src_hazard(input logic [4:0] src, input logic use_it, input logic [1:0] tuse);
        bit hit_e, hit_m;
        hit_e = (src == WriteRegE) && (int'(tnewE) > int'(tuse));
        hit_m = (src == WriteRegM) && (int'(tnewM) > int'(tuse));
        return use_it && (src != 0) && (hit_e || hit_m);
    endfunction

    function automatic bit model_stall();
        bit md;
        md = mdUseD && ((m_count > 0) || mdStartE);
        return src_hazard(rsD, useRsD, tuseRsD) || src_hazard(rtD, useRtD, tuseRtD) || md;
    endfunction

    // Advance one clock and move the model by the same rules.
    task automatic tick();
        bit s;
        s = model_stall();
        @(posedge clk);
        if (reset) begin
            m_count  = 0;
            m_stalls = 0;
        end else begin
            if (s && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (m_count > 0) m_count = m_count - 1;
            else if (mdStartE) m_count = mdIsDivE ? 10 : 5;
        end
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; useRsD = 0; useRtD = 0; tuseRsD = 0; tuseRtD = 0;
        WriteRegE = 0; tnewE = 0; WriteRegM = 0; tnewM = 0;
        mdStartE = 0; mdIsDivE = 0; mdUseD = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        m_count = 0; m_stalls = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        total++;
        if (mdCount !== 4'd0 || mdBusy !== 1'b0 || stallCount !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: mdCount=%0d mdBusy=%0b stallCount=%0d, want 0/0/0", mdCount, mdBusy, stallCount);
        end
        total++;
        if (stallF !== 1'b0 || stallD !== 1'b0 || flushE !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_stall: stallF/D/flushE=%b%b%b, want 000", stallF, stallD, flushE);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        WriteRegE = 8; tnewE = 2; useRsD = 1; rsD = 8; tuseRsD = 1;
        #1;
        total++;
        if (stallF !== 1'b1 || stallD !== 1'b1 || flushE !== 1'b1) begin
            bad++;
            $display("[TB] FAIL load_use_stall: stallF/D/flushE=%b%b%b, want 111", stallF, stallD, flushE);
        end
        tick();
        WriteRegE = 0; WriteRegM = 8; tnewM = 1;
        #1;
        total++;
        if (stallF !== 1'b0 || flushE !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_use_release: stallF=%b flushE=%b, want 0", stallF, flushE);
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        useRtD = 1; rtD = 9; tuseRtD = 0; WriteRegE = 9; tnewE = 1;
        #1;
        total++;
        if (stallD !== 1'b1) begin
            bad++;
            $display("[TB] FAIL branch_alu_stall: stallD=%b, want 1", stallD);
        end
        tick();
        rtD = 0; WriteRegE = 0;
        #1;
        total++;
        if (stallD !== 1'b0) begin
            bad++;
            $display("[TB] FAIL branch_reg0: stallD=%b, want 0", stallD);
        end
        tick();
    endtask

    task automatic test_mult();
        clear_inputs();
        mdStartE = 1; mdIsDivE = 0;
        tick();
        mdStartE = 0;
        total++;
        if (mdCount !== 4'd5 || mdBusy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mult_load: mdCount=%0d mdBusy=%b, want 5/1", mdCount, mdBusy);
        end
        mdUseD = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (stallF !== 1'b1 || mdCount !== 4'(5 - i)) begin
                bad++;
                $display("[TB] FAIL mult_busy_stall: cycle %0d stallF=%b mdCount=%0d, want 1/%0d", i, stallF, mdCount, 5 - i);
            end
            tick();
        end
        #1;
        total++;
        if (stallF !== 1'b0 || mdCount !== 4'd0 || mdBusy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mult_release: stallF=%b mdCount=%0d mdBusy=%b, want 0/0/0", stallF, mdCount, mdBusy);
        end
        mdUseD = 0;
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        mdStartE = 1; mdIsDivE = 1;
        tick();
        for (int k = 10; k >= 1; k--) begin
            total++;
            if (mdCount !== 4'(k)) begin
                bad++;
                $display("[TB] FAIL div_countdown: mdCount=%0d, want %0d", mdCount, k);
            end
            tick();
        end
        total++;
        if (mdCount !== 4'd0 || mdBusy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL div_done: mdCount=%0d mdBusy=%b, want 0/0", mdCount, mdBusy);
        end
        mdStartE = 0;
        tick();
        tick();
    endtask

    task automatic test_same_cycle();
        clear_inputs();
        mdStartE = 1; mdUseD = 1;
        #1;
        total++;
        if (mdCount !== 4'd0 || stallF !== 1'b1) begin
            bad++;
            $display("[TB] FAIL md_same_cycle: mdCount=%0d stallF=%b, want 0/1", mdCount, stallF);
        end
        tick();
        mdStartE = 0; mdUseD = 0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        mdStartE = 1; mdIsDivE = 1;
        tick();
        mdStartE = 0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (mdCount !== 4'd6) begin
            bad++;
            $display("[TB] FAIL mid_div_count: mdCount=%0d, want 6", mdCount);
        end
        reset = 1'b1;
        useRsD = 1; rsD = 8; WriteRegE = 8; tnewE = 2; tuseRsD = 0;
        #1;
        total++;
        if (stallF !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_in_reset: stallF=%b, want 1", stallF);
        end
        tick();
        reset = 1'b0;
        useRsD = 0;
        #1;
        total++;
        if (mdCount !== 4'd0 || mdBusy !== 1'b0 || stallCount !== 32'd0) begin
            bad++;
            $display("[TB] FAIL mid_div_reset: mdCount=%0d mdBusy=%b stallCount=%0d, want 0/0/0", mdCount, mdBusy, stallCount);
        end
        useRsD = 1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (stallCount !== 32'd3) begin
            bad++;
            $display("[TB] FAIL stall_count3: stallCount=%0d, want 3", stallCount);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rsD       = 5'($urandom_range(0, 3));
            rtD       = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            WriteRegM = 5'($urandom_range(0, 3));
            useRsD    = 1'($urandom);
            useRtD    = 1'($urandom);
            tuseRsD   = 2'($urandom);
            tuseRtD   = 2'($urandom);
            tnewE     = 2'($urandom);
            tnewM     = 2'($urandom);
            mdStartE  = ($urandom_range(0, 5) == 0);
            mdIsDivE  = 1'($urandom);
            mdUseD    = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 60) == 0);
            #1;
            total++;
            if (stallF !== model_stall() || stallD !== stallF || flushE !== stallF) begin
                bad++;
                $display("[TB] FAIL rand_stall: n=%0d stallF/D/flushE=%b%b%b, want %b", n, stallF, stallD, flushE, model_stall());
            end
            total++;
            if (mdCount !== 4'(m_count) || mdBusy !== (m_count > 0) || stallCount !== m_stalls[31:0]) begin
                bad++;
                $display("[TB] FAIL rand_regs: n=%0d mdCount=%0d mdBusy=%b stallCount=%0d, want %0d/%b/%0d",
                         n, mdCount, mdBusy, stallCount, m_count, (m_count > 0), m_stalls[31:0]);
            end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mult();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage pipelined CPU. It compares D-stage source operands against the E and M stage destinations using Tuse/Tnew timing. It also tracks the multi-cycle multiply/divide unit (MDU) with an internal busy counter. It drives the stall signals for the F/D pipeline registers and the bubble/flush signal for the D/E pipeline register.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu issues in E.
DIV_CYCLES, 10, busy cycles after a div/divu issues in E.
CNT_W, 4, width of the MDU busy counter. Must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
rsD  input  5  D-stage rs register number.
rtD  input  5  D-stage rt register number.
useRsD  input  1  D instruction reads rs.
useRtD  input  1  D instruction reads rt.
tuseRsD  input  2  cycles until rs is needed (0 = in D, 1 = in E, 2 = in M).
tuseRtD  input  2  cycles until rt is needed.
WriteRegE  input  5  E-stage destination register (0 = none).
tnewE  input  2  cycles until the E result is available for forwarding.
WriteRegM  input  5  M-stage destination register (0 = none).
tnewM  input  2  cycles until the M result is available.
mdStartE  input  1  a mult/div instruction is in E this cycle.
mdIsDivE  input  1  qualifies mdStartE: 1 = div/divu, 0 = mult/multu.
mdUseD  input  1  D instruction is an MDU op (mult/div/mfhi/mflo/mthi/mtlo).
stallF  output  1  hold PC.
stallD  output  1  hold the F/D register.
flushE  output  1  load a bubble (all zero) into the D/E register.
mdBusy  output  1  MDU computing; registered.
mdCount  output  CNT_W  remaining MDU busy cycles; registered.
stallCount  output  32  saturating count of stalled cycles; registered.

Behaviour:
- Data stall terms:
  - rsE = useRsD & (rsD != 0) & (rsD == WriteRegE) & (tnewE > tuseRsD)
  - rsM = useRsD & (rsD != 0) & (rsD == WriteRegM) & (tnewM > tuseRsD)
  - rtE and rtM are defined the same way using rtD, useRtD and tuseRtD.
  - All comparisons are unsigned.
- MDU stall: mdStall = mdUseD & (mdBusy | mdStartE).
- Combined stall: stall = rsE | rsM | rtE | rtM | mdStall.
- stallF = stallD = flushE = stall. These are purely combinational and take effect in the same cycle with zero latency.
- MDU counter, priority high to low:
  - reset: mdCount <= 0.
  - mdStartE & (mdCount == 0): mdCount <= mdIsDivE ? DIV_CYCLES : MULT_CYCLES.
  - mdCount != 0: mdCount <= mdCount - 1. Any mdStartE in this cycle is ignored. It cannot legally occur, because an MDU op in D is held while busy.
  - otherwise: hold at 0.
- mdBusy = (mdCount != 0), taken from the registered count.
  - mdBusy rises on the edge after mdStartE.
  - It stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - The counter never wraps below 0.
- stallCount:
  - reset: 0.
  - Increments by 1 on each rising edge where stall = 1.
  - Saturates at 32'hFFFF_FFFF.
- The controller never stalls on register 0, even when WriteReg matches.
- A stall never clears in-flight MDU state. An MDU stall and a data stall in the same cycle produce a single stall.
- Reset values: mdCount = 0, mdBusy = 0, stallCount = 0. stallF, stallD and flushE follow their inputs combinationally during and after reset.
- Reset asserted mid-operation (mdCount != 0) clears the counter on that edge. mdBusy = 0 the next cycle.

Test Plan:
- Load-use: WriteRegE=8, tnewE=2, useRsD=1, rsD=8, tuseRsD=1 -> stallF=stallD=flushE=1. The next cycle, with WriteRegM=8, tnewM=1, tuseRsD=1 and no E match -> stall=0.
- Branch needing ALU result: rtD=9, tuseRtD=0, WriteRegE=9, tnewE=1 -> stall=1. WriteRegE=0 with rtD=0 -> stall=0.
- Mult: pulse mdStartE=1, mdIsDivE=0 -> next cycle mdCount=5, mdBusy=1. mdUseD=1 stalls for 5 cycles, then mdCount=0 and stall releases.
- Div back-to-back: mdStartE with mdIsDivE=1 -> mdCount=10. A further mdStartE while busy leaves the countdown 10,9,...,1,0 unchanged.
- mdUseD=1 in the same cycle as mdStartE=1 (mdCount=0) -> stall=1 that cycle.
- Reset mid-div at mdCount=6 -> next cycle mdCount=0, mdBusy=0, stallCount=0. Then 3 forced stall cycles -> stallCount=3.
